// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame shape,
// used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } rx_word_t;

endpackage

// File: rtl/rx_uart_if.sv
// Receive-side output bus: byte, status flags and the
// valid/ready handshake towards the consumer.
interface rx_uart_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 i_ready;

  modport master (
    output o_data,
    output o_valid,
    output o_parity_err,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_parity_err,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous, idle-high line.
// Both stages come out of reset at 1 so no false start is seen.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// Oversampling UART receiver: 8 data bits, optional parity,
// one stop bit, single-entry output register with overrun pulse.
module rx_uart
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         baud_tick,
  input  logic         serial_in,
  output logic         o_busy,
  rx_uart_if.master    rx
);

  localparam int CW =
    (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF =
    CW'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);
  localparam logic ODD = 1'(PARITY_ODD);

  logic                 rx_s;
  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 armed;
  logic                 at_last;
  logic                 complete;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

  assign at_last  = (cnt == LAST);
  assign complete = baud_tick && at_last
                 && (state == ST_STOP);
  assign o_busy   = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bidx            <= '0;
      shreg           <= '0;
      perr_q          <= 1'b0;
      armed           <= 1'b0;
      rx.o_data       <= '0;
      rx.o_valid      <= 1'b0;
      rx.o_parity_err <= 1'b0;
      rx.o_frame_err  <= 1'b0;
      rx.o_overrun    <= 1'b0;
    end else begin
      rx.o_overrun <= 1'b0;

      if (complete) begin
        if (!rx.o_valid || rx.i_ready) begin
          rx.o_data       <= shreg;
          rx.o_parity_err <= (PARITY_EN != 0) && perr_q;
          rx.o_frame_err  <= !rx_s;
          rx.o_valid      <= 1'b1;
        end else begin
          rx.o_overrun <= 1'b1;
        end
      end else if (rx.o_valid && rx.i_ready) begin
        rx.o_valid <= 1'b0;
      end

      if (baud_tick) begin
        unique case (state)
          ST_IDLE: begin
            // armed stays low after a low stop bit
            if (rx_s) begin
              armed <= 1'b1;
            end else if (armed) begin
              cnt   <= '0;
              state <= ST_START;
            end
          end
          ST_START: begin
            if (cnt == HALF) begin
              cnt   <= '0;
              bidx  <= '0;
              state <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (at_last) begin
              cnt   <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              bidx  <= bidx + 1'b1;
              if (bidx == LAST_BIT) begin
                state <= (PARITY_EN != 0)
                       ? ST_PARITY : ST_STOP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (at_last) begin
              cnt    <= '0;
              perr_q <= ((^shreg) ^ rx_s) != ODD;
              state  <= ST_STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (at_last) begin
              cnt   <= '0;
              armed <= rx_s;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: frames driven bit by bit on the
// baud tick grid, expected bytes scoreboarded and checked on output.
module tb_rx_uart;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic baud_tick = 1'b0;
  logic serial_in = 1'b1;
  logic o_busy;
  int   div = 0;
  int   ovr_cnt = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  rx_uart_if rif ();

  rx_uart #(
    .OVERSAMPLE (16),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .serial_in (serial_in),
    .o_busy    (o_busy),
    .rx        (rif.master)
  );

  always #5 clk = ~clk;

  // one tick every 4 clocks, changed away from the active edge
  always @(negedge clk) begin
    div       <= (div == 3) ? 0 : div + 1;
    baud_tick <= (div == 3);
  end

  always @(negedge clk)
    if (rif.o_overrun === 1'b1) ovr_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // returns inside a tick cycle, before its active edge
  task automatic wait_tick();
    do begin
      @(negedge clk);
      #1;
    end while (!baud_tick);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic sb,
                            input int nbits,
                            input int rdy_at);
    logic [10:0] bits;
    int k;
    bits = {sb, p, d, 1'b0};
    wait_tick();
    for (int i = 0; i < nbits; i++) begin
      serial_in = bits[i];
      for (int t = 1; t <= 16; t++) begin
        wait_tick();
        k = i * 16 + t;
        if (k == rdy_at) begin
          rif.i_ready = 1'b1;
          @(posedge clk);
          #1;
          rif.i_ready = 1'b0;
        end
      end
    end
    if (nbits == 11) begin
      serial_in = 1'b1;
      wait_ticks(4);
    end
  endtask

  task automatic push_exp(input logic [7:0] d,
                          input logic pe,
                          input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sbq.push_back(e);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 400; n++) begin
      if (rif.o_valid === 1'b1) break;
      @(negedge clk);
      #1;
    end
    chk({tag, "_valid"}, 32'(rif.o_valid), 32'd1);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_data"}, 32'(rif.o_data), 32'(e.d));
      chk({tag, "_perr"}, 32'(rif.o_parity_err),
          32'(e.pe));
      chk({tag, "_ferr"}, 32'(rif.o_frame_err),
          32'(e.fe));
    end
  endtask

  task automatic accept(input string tag);
    rif.i_ready = 1'b1;
    @(posedge clk);
    #1;
    rif.i_ready = 1'b0;
    chk({tag, "_drain"}, 32'(rif.o_valid), 32'd0);
  endtask

  task automatic rx_frame(input string tag,
                          input logic [7:0] d,
                          input logic p,
                          input logic sb,
                          input logic pe,
                          input logic fe);
    push_exp(d, pe, fe);
    send_frame(d, p, sb, 11, -1);
    wait_valid(tag);
    check_out(tag);
    accept(tag);
  endtask

  initial begin
    rif.i_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(rif.o_valid), 32'd0);
    chk("rst_data", 32'(rif.o_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ovr", 32'(rif.o_overrun), 32'd0);
    chk("rst_ferr", 32'(rif.o_frame_err), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(20);

    rx_frame("a5", 8'hA5, even_par(8'hA5), 1'b1,
             1'b0, 1'b0);

    // short low pulse must be rejected at mid start bit
    wait_tick();
    serial_in = 1'b0;
    wait_ticks(4);
    chk("glitch_busy", 32'(o_busy), 32'd1);
    serial_in = 1'b1;
    wait_ticks(16);
    chk("glitch_idle", 32'(o_busy), 32'd0);
    chk("glitch_novalid", 32'(rif.o_valid), 32'd0);

    rx_frame("par01", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    rx_frame("good5a", 8'h5A, even_par(8'h5A), 1'b1,
             1'b0, 1'b0);

    rx_frame("fe3c", 8'h3C, even_par(8'h3C), 1'b0,
             1'b0, 1'b1);
    wait_ticks(8);
    rx_frame("after55", 8'h55, even_par(8'h55), 1'b1,
             1'b0, 1'b0);

    // second frame dropped while the first is unconsumed
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, even_par(8'h11), 1'b1, 11, -1);
    wait_valid("ovr11");
    send_frame(8'h22, even_par(8'h22), 1'b1, 11, -1);
    chk("ovr_pulse", 32'(ovr_cnt), 32'd1);
    check_out("ovr11");
    accept("ovr11");

    // consumer ready in the stop-sample cycle of frame 2
    push_exp(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, even_par(8'h11), 1'b1, 11, -1);
    wait_valid("rdy11");
    check_out("rdy11");
    push_exp(8'h22, 1'b0, 1'b0);
    send_frame(8'h22, even_par(8'h22), 1'b1, 11, 169);
    chk("rdy_noovr", 32'(ovr_cnt), 32'd1);
    wait_valid("rdy22");
    check_out("rdy22");

    // reset in the middle of data bit 4, byte 0x22 still held
    send_frame(8'h7E, even_par(8'h7E), 1'b1, 5, -1);
    serial_in = 1'b1;
    wait_ticks(8);
    chk("mid_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rif.o_valid), 32'd0);
    chk("mid_rst_data", 32'(rif.o_data), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(20);
    chk("post_rst_novalid", 32'(rif.o_valid), 32'd0);
    rx_frame("7e", 8'h7E, even_par(8'h7E), 1'b1,
             1'b0, 1'b0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("ovr_final", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_uart.md
RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: number of baud_tick pulses per bit period.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 means a parity bit follows data bit 7.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port baud_tick, input, 1: one-clk-wide enable at OVERSAMPLE x baud rate.
REQ-007 SHALL have port serial_in, input, 1: asynchronous line, idle high.
REQ-008 SHALL have port i_ready, input, 1: consumer accepts o_data when i_ready and o_valid are both high.
REQ-009 SHALL have port o_data, output, 8: received byte.
REQ-010 SHALL have port o_valid, output, 1: o_data holds an unconsumed byte.
REQ-011 SHALL have port o_parity_err, output, 1: parity mismatch flag, qualified by o_valid.
REQ-012 SHALL have port o_frame_err, output, 1: stop bit sampled low, qualified by o_valid.
REQ-013 SHALL have port o_overrun, output, 1: one-clk pulse when a completed frame is dropped.
REQ-014 SHALL have port o_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 SHALL pass serial_in through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rx_s.
REQ-016 SHALL advance the state machine, the tick counter (log2 OVERSAMPLE bits) and the bit index (3 bits) only in clk cycles where baud_tick=1.
REQ-017 State IDLE: on a tick with rx_s=0, clear the tick counter and go to START.
REQ-018 State START: at tick count OVERSAMPLE/2-1, if rx_s=0, clear the counter and go to DATA; if rx_s=1, go to IDLE (glitch, no output).
REQ-019 State DATA: at tick count OVERSAMPLE-1, shift rx_s into the shift register LSB-first and increment the bit index; after bit 7, go to PARITY if PARITY_EN=1, else go to STOP.
REQ-020 State PARITY: at tick count OVERSAMPLE-1, set the parity error to (XOR of the 8 data bits XOR rx_s) != PARITY_ODD, then go to STOP.
REQ-021 State STOP: at tick count OVERSAMPLE-1, set the frame error to !rx_s, perform completion, then go to IDLE; a low stop bit SHALL NOT cause an extra start detection until rx_s is seen high for at least one tick.
REQ-022 Completion when o_valid=0 or i_ready=1 in the same cycle: load o_data, o_parity_err and o_frame_err on the next clk edge and hold o_valid high.
REQ-023 Completion when o_valid=1 and i_ready=0: keep the old o_data and flags unchanged and pulse o_overrun for one clk.
REQ-024 o_valid SHALL clear on the clk edge after a cycle with i_ready=1 and o_valid=1, unless completion occurs in that same cycle.
REQ-025 When PARITY_EN=0, o_parity_err SHALL be 0.
REQ-026 Latency: o_valid rises 1 clk after the baud_tick that samples the stop bit.
REQ-027 i_ready SHALL have no effect while o_valid=0.

Reset
REQ-028 On reset assertion, without waiting for clk: state=IDLE, counters=0, shift register=0, synchronizer=1.
REQ-029 On reset assertion, without waiting for clk: o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0, o_busy=0.
REQ-030 Reset mid-frame SHALL discard the partial byte; after release, reception starts only at a new falling edge.

Structure
REQ-031 The state encoding (IDLE, START, DATA, PARITY, STOP) and the frame constants (8 data bits, 1 stop bit) SHALL live in a shared uart_pkg package, also used by the transmitter.
REQ-032 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff; all other logic stays in rx_uart.

Verification
REQ-033 Frame 0xA5, even parity bit 0, stop bit 1, 16 ticks/bit -> o_data=0xA5, o_valid=1, o_parity_err=0, o_frame_err=0.
REQ-034 serial_in low for 4 ticks, then high -> no o_valid, state back to IDLE, o_busy high only during the glitch.
REQ-035 Frame 0x01 with parity bit 0 (even) -> o_data=0x01, o_parity_err=1; the next good frame clears the flag.
REQ-036 Frame 0x3C with stop bit 0 -> o_frame_err=1, o_valid=1; the line returns high and the next frame 0x55 is received correctly.
REQ-037 Two frames 0x11 then 0x22 with i_ready=0 -> o_data stays 0x11, o_overrun pulses once; with i_ready=1 held in the completion cycle of the second frame -> o_data=0x22 and no overrun.
REQ-038 Reset asserted during data bit 4 -> all outputs 0 immediately; the following frame 0x7E is received intact.
